// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core. Every instruction walks an FSM
// (FETCH/DECODE/EXECUTE/MEM/WB) over a single shared memory port with a
// req/ready handshake, so any access can be stretched by slow memory.
// EBREAK parks the core in HALT. Illegal encodings, out-of-range register
// indices and misaligned targets park it in TRAP with the PC left on the
// faulting instruction.
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              trap,
    output logic [31:0]       instret,
    output logic [ADDR_W-1:0] pc_out
);

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXECUTE = 3'd2;
    localparam logic [2:0] ST_MEM     = 3'd3;
    localparam logic [2:0] ST_WB      = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;
    localparam logic [2:0] ST_TRAP    = 3'd6;

    localparam int         IDX_W = $clog2(NUM_REGS);
    localparam logic [5:0] NREG  = 6'(NUM_REGS);

    // Architectural and micro-architectural state
    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       ir_reg;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [31:0]       alu_out_reg;
    logic [31:0]       mdr_reg;
    logic [31:0]       instret_reg;
    logic [31:0]       reg_file [NUM_REGS];

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = ir_reg[6:0];
    assign rd     = ir_reg[11:7];
    assign funct3 = ir_reg[14:12];
    assign rs1    = ir_reg[19:15];
    assign rs2    = ir_reg[24:20];
    assign funct7 = ir_reg[31:25];

    // Sign-extended immediates for every format
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
    assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};
    assign imm_u = {ir_reg[31:12], 12'b0};

    // Instruction class flags
    logic is_op;
    logic is_opimm;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_ebreak;
    logic legal;

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_ebreak = (ir_reg == 32'h0010_0073);

    // Only the supported funct3/funct7 combinations are legal
    always_comb begin
        legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000)
                    legal = (funct3 != 3'b011);
                else if (funct7 == 7'b0100000)
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end
            7'b0010011: legal = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110) ||
                                (funct3 == 3'b100) || (funct3 == 3'b010);
            7'b0000011: legal = (funct3 == 3'b010);
            7'b0100011: legal = (funct3 == 3'b010);
            7'b1100011: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100);
            7'b1101111: legal = 1'b1;
            7'b1100111: legal = (funct3 == 3'b000);
            7'b0110111: legal = 1'b1;
            7'b1110011: legal = is_ebreak;
            default:    legal = 1'b0;
        endcase
    end

    // Register indices actually used by the instruction; unused fields are don't-care
    logic uses_rs1;
    logic uses_rs2;
    logic uses_rd;
    logic bad_reg;

    assign uses_rs1 = is_op | is_opimm | is_load | is_store | is_branch | is_jalr;
    assign uses_rs2 = is_op | is_store | is_branch;
    assign uses_rd  = is_op | is_opimm | is_load | is_jal | is_jalr | is_lui;
    assign bad_reg  = (uses_rs1 && ({1'b0, rs1} >= NREG)) ||
                      (uses_rs2 && ({1'b0, rs2} >= NREG)) ||
                      (uses_rd  && ({1'b0, rd}  >= NREG));

    // ALU: second operand is B for R-type, immediate for I-type
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    assign alu_b = is_op ? b_reg : imm_i;

    always_comb begin
        alu_result = 32'h0;
        case (funct3)
            3'b000:  alu_result = (is_op && funct7[5]) ? (a_reg - alu_b) : (a_reg + alu_b);
            3'b111:  alu_result = a_reg & alu_b;
            3'b110:  alu_result = a_reg | alu_b;
            3'b100:  alu_result = a_reg ^ alu_b;
            3'b010:  alu_result = {31'b0, ($signed(a_reg) < $signed(alu_b))};
            3'b001:  alu_result = a_reg << alu_b[4:0];
            3'b101:  alu_result = funct7[5] ? 32'($signed(a_reg) >>> alu_b[4:0])
                                            : (a_reg >> alu_b[4:0]);
            default: alu_result = 32'h0;
        endcase
    end

    // Branch condition and control-flow targets (PC arithmetic wraps at ADDR_W)
    logic              branch_taken;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [31:0]       eff_addr;
    logic [31:0]       jalr_sum;

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (a_reg == b_reg);
            3'b001:  branch_taken = (a_reg != b_reg);
            3'b100:  branch_taken = ($signed(a_reg) < $signed(b_reg));
            default: branch_taken = 1'b0;
        endcase
    end

    assign pc_plus4      = pc_reg + ADDR_W'(4);
    assign branch_target = pc_reg + ADDR_W'(imm_b);
    assign jalr_sum      = (a_reg + imm_i) & ~32'd1;
    assign jump_target   = is_jal ? (pc_reg + ADDR_W'(imm_j)) : ADDR_W'(jalr_sum);
    assign eff_addr      = a_reg + (is_store ? imm_s : imm_i);

    // Write-back port into the register file
    logic        wb_en;
    logic [31:0] wb_data;

    assign wb_en   = (state_reg == ST_WB) && uses_rd && (rd != 5'd0);
    assign wb_data = is_load ? mdr_reg : alu_out_reg;

    // Register file: cleared on reset, x0 never written so it always reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                reg_file[i] <= 32'h0;
        end else if (wb_en) begin
            reg_file[rd[IDX_W-1:0]] <= wb_data;
        end
    end

    // Main FSM: sequences each instruction and owns PC, IR, A/B, ALUOut, MDR, instret
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FETCH;
            pc_reg      <= ADDR_W'(RESET_PC);
            ir_reg      <= 32'h0;
            a_reg       <= 32'h0;
            b_reg       <= 32'h0;
            alu_out_reg <= 32'h0;
            mdr_reg     <= 32'h0;
            instret_reg <= 32'h0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_reg    <= mem_rdata;
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    a_reg <= reg_file[rs1[IDX_W-1:0]];
                    b_reg <= reg_file[rs2[IDX_W-1:0]];
                    if (!legal || bad_reg)
                        state_reg <= ST_TRAP;
                    else if (is_ebreak)
                        state_reg <= ST_HALT;
                    else
                        state_reg <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (is_branch) begin
                        // Branches retire here; a misaligned taken target faults instead
                        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                            state_reg <= ST_TRAP;
                        end else begin
                            pc_reg      <= branch_taken ? branch_target : pc_plus4;
                            instret_reg <= instret_reg + 32'd1;
                            state_reg   <= ST_FETCH;
                        end
                    end else if (is_jal || is_jalr) begin
                        if (jump_target[1:0] != 2'b00) begin
                            state_reg <= ST_TRAP;
                        end else begin
                            alu_out_reg <= 32'(pc_plus4);
                            pc_reg      <= jump_target;
                            state_reg   <= ST_WB;
                        end
                    end else if (is_load || is_store) begin
                        alu_out_reg <= eff_addr;
                        state_reg   <= (eff_addr[1:0] != 2'b00) ? ST_TRAP : ST_MEM;
                    end else if (is_lui) begin
                        alu_out_reg <= imm_u;
                        state_reg   <= ST_WB;
                    end else begin
                        alu_out_reg <= alu_result;
                        state_reg   <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (is_load) begin
                            mdr_reg   <= mem_rdata;
                            state_reg <= ST_WB;
                        end else begin
                            pc_reg      <= pc_plus4;
                            instret_reg <= instret_reg + 32'd1;
                            state_reg   <= ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    // Jumps already moved the PC in EXECUTE
                    if (!(is_jal || is_jalr))
                        pc_reg <= pc_plus4;
                    instret_reg <= instret_reg + 32'd1;
                    state_reg   <= ST_FETCH;
                end
                ST_HALT:  state_reg <= ST_HALT;
                ST_TRAP:  state_reg <= ST_TRAP;
                default:  state_reg <= ST_TRAP;
            endcase
        end
    end

    // Memory port: driven straight from state so it holds steady while mem_ready is low
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (!rst) begin
            if (state_reg == ST_FETCH) begin
                mem_req  = 1'b1;
                mem_addr = pc_reg;
            end else if (state_reg == ST_MEM) begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                mem_addr  = ADDR_W'(alu_out_reg);
                mem_wdata = is_store ? b_reg : 32'h0;
            end
        end
    end

    assign halted  = (state_reg == ST_HALT) || (state_reg == ST_TRAP);
    assign trap    = (state_reg == ST_TRAP);
    assign instret = instret_reg;
    assign pc_out  = pc_reg;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: small hand-assembled programs
// run from 0x80 against a memory model with optional wait states.
module tb_riscv_multicycle_core;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        halted;
    logic        trap;
    logic [31:0] instret;
    logic [31:0] pc_out;

    // Second core configured RV32E-style, fed a single ADD x17,x1,x2
    logic        mem2_req;
    logic        mem2_we;
    logic [31:0] mem2_addr;
    logic [31:0] mem2_wdata;
    logic [31:0] mem2_rdata;
    logic        mem2_ready;
    logic        halted2;
    logic        trap2;
    logic [31:0] instret2;
    logic [31:0] pc2;

    riscv_multicycle_core #(.RESET_PC(32'h80), .NUM_REGS(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .halted(halted), .trap(trap), .instret(instret), .pc_out(pc_out)
    );

    riscv_multicycle_core #(.RESET_PC(32'h80), .NUM_REGS(16), .ADDR_W(32)) dut_e (
        .clk(clk), .rst(rst),
        .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
        .mem_rdata(mem2_rdata), .mem_ready(mem2_ready),
        .halted(halted2), .trap(trap2), .instret(instret2), .pc_out(pc2)
    );

    assign mem2_ready = 1'b1;
    assign mem2_rdata = (mem2_addr == 32'h80) ? 32'h0020_88B3 : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: program image written by the stimulus, store data kept separately
    logic [31:0] mem   [0:255];
    logic [31:0] dmem  [0:255];
    logic        dvalid[0:255];
    int          stall_cycles;
    logic        hold_writes;
    int          n_writes;
    int          n_reads;
    int          addr_unstable;
    logic [31:0] wlog_addr [0:15];
    logic [31:0] wlog_data [0:15];
    int          wait_cnt;
    logic        waiting;
    logic [31:0] held_addr;

    assign mem_rdata = dvalid[mem_addr[9:2]] ? dmem[mem_addr[9:2]] : mem[mem_addr[9:2]];

    initial begin
        mem_ready     = 1'b0;
        n_writes      = 0;
        n_reads       = 0;
        addr_unstable = 0;
        wait_cnt      = 0;
        waiting       = 1'b0;
        held_addr     = 32'h0;
        for (int i = 0; i < 256; i++) begin
            dvalid[i] = 1'b0;
            dmem[i]   = 32'h0;
        end
    end

    // Responder decides mem_ready mid-cycle; the transfer completes on the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            waiting   = 1'b0;
            for (int i = 0; i < 256; i++) dvalid[i] = 1'b0;
        end else if (mem_req) begin
            if (waiting && (mem_addr != held_addr)) addr_unstable++;
            if ((mem_we && hold_writes) || (wait_cnt < stall_cycles)) begin
                mem_ready = 1'b0;
                wait_cnt++;
                waiting   = 1'b1;
                held_addr = mem_addr;
            end else begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                waiting   = 1'b0;
                if (mem_we) begin
                    dmem[mem_addr[9:2]]   = mem_wdata;
                    dvalid[mem_addr[9:2]] = 1'b1;
                    wlog_addr[n_writes % 16] = mem_addr;
                    wlog_data[n_writes % 16] = mem_wdata;
                    n_writes++;
                end else begin
                    n_reads++;
                end
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            waiting   = 1'b0;
        end
    end

    int errors;
    int checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Counts rising edges until instret reaches target; bounded
    task automatic wait_instret(input logic [31:0] target, input int budget, output int cycles);
        cycles = 0;
        while ((instret != target) && (cycles < budget)) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("reach_instret", instret, target);
    endtask

    task automatic wait_halt(input int budget);
        int n;
        n = 0;
        while (!halted && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("halted", 32'(halted), 32'd1);
    endtask

    int cyc;
    int wbase;
    int rbase;
    int ubase;

    initial begin
        errors       = 0;
        checks       = 0;
        stall_cycles = 0;
        hold_writes  = 1'b0;
        rst          = 1'b1;
        clear_mem();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_pc", pc_out, 32'h80);

        // Arithmetic: ADDI/ADDI/ADD, store the sum, EBREAK
        load(32'h80, enc_i(5, 0, 0, 1, 7'h13));
        load(32'h84, enc_i(-3, 0, 0, 2, 7'h13));
        load(32'h88, enc_r(0, 2, 1, 0, 3));
        load(32'h8C, enc_s(32'h40, 3, 0));
        load(32'h90, 32'h0010_0073);
        wbase = n_writes;
        rst = 1'b0;
        wait_instret(3, 40, cyc);
        check("alu3_cycles", cyc, 12);
        wait_halt(40);
        check("ebreak_trap", 32'(trap), 32'd0);
        check("ebreak_instret", instret, 32'd4);
        check("ebreak_pc", pc_out, 32'h90);
        check("alu_nwrites", n_writes - wbase, 1);
        check("alu_waddr", wlog_addr[wbase % 16], 32'h40);
        check("alu_sum", wlog_data[wbase % 16], 32'd2);

        // Same program with two wait states per transfer
        stall_cycles = 2;
        do_reset();
        wbase = n_writes;
        ubase = addr_unstable;
        wait_instret(3, 60, cyc);
        check("stall_cycles", cyc, 18);
        wait_halt(60);
        check("stall_addr_stable", addr_unstable - ubase, 0);
        check("stall_sum", wlog_data[wbase % 16], 32'd2);
        stall_cycles = 0;

        // Load/store round trip
        clear_mem();
        load(32'h80, enc_i(32'h100, 0, 0, 1, 7'h13));
        load(32'h84, enc_s(4, 1, 1));
        load(32'h88, enc_i(4, 1, 2, 5, 7'h03));
        load(32'h8C, enc_s(32'h40, 5, 0));
        load(32'h90, 32'h0010_0073);
        do_reset();
        wbase = n_writes;
        wait_instret(1, 20, cyc);
        wait_instret(2, 20, cyc);
        check("sw_cycles", cyc, 4);
        check("sw_addr", wlog_addr[wbase % 16], 32'h104);
        check("sw_data", wlog_data[wbase % 16], 32'h100);
        wait_instret(3, 20, cyc);
        check("lw_cycles", cyc, 5);
        wait_halt(40);
        check("lw_value", wlog_data[(wbase + 1) % 16], 32'h100);
        check("lw_trap", 32'(trap), 32'd0);

        // Branches and jumps
        clear_mem();
        load(32'h80, enc_b(8, 0, 0, 0));
        load(32'h84, enc_i(1, 0, 0, 2, 7'h13));
        load(32'h88, enc_b(8, 0, 0, 1));
        load(32'h8C, enc_j(16, 0));
        load(32'h90, enc_s(32'h40, 1, 0));
        load(32'h94, enc_s(32'h44, 2, 0));
        load(32'h98, 32'h0010_0073);
        load(32'h9C, enc_j(-12, 1));
        do_reset();
        wbase = n_writes;
        wait_instret(1, 20, cyc);
        check("beq_cycles", cyc, 3);
        check("beq_pc", pc_out, 32'h88);
        wait_instret(2, 20, cyc);
        check("bne_cycles", cyc, 3);
        check("bne_pc", pc_out, 32'h8C);
        wait_instret(3, 20, cyc);
        check("jal_fwd_pc", pc_out, 32'h9C);
        wait_halt(60);
        check("jal_link", wlog_data[wbase % 16], 32'hA0);
        check("skipped_x2", wlog_data[(wbase + 1) % 16], 32'h0);
        check("jump_instret", instret, 32'd6);
        check("jump_pc", pc_out, 32'h98);

        // x0 stays zero, BLT signed taken, then an illegal opcode
        clear_mem();
        load(32'h80, enc_i(7, 0, 0, 0, 7'h13));
        load(32'h84, enc_i(-1, 0, 0, 1, 7'h13));
        load(32'h88, enc_b(8, 0, 1, 4));
        load(32'h8C, 32'h0010_0073);
        load(32'h90, enc_s(32'h40, 0, 0));
        load(32'h94, 32'h0000_007F);
        do_reset();
        wbase = n_writes;
        wait_halt(60);
        check("x0_value", wlog_data[wbase % 16], 32'h0);
        check("illegal_trap", 32'(trap), 32'd1);
        check("illegal_pc", pc_out, 32'h94);
        check("illegal_instret", instret, 32'd4);

        // Misaligned load faults without touching memory
        clear_mem();
        load(32'h80, enc_i(32'h100, 0, 0, 1, 7'h13));
        load(32'h84, enc_i(2, 1, 2, 5, 7'h03));
        do_reset();
        rbase = n_reads;
        wbase = n_writes;
        wait_halt(40);
        check("mis_trap", 32'(trap), 32'd1);
        check("mis_pc", pc_out, 32'h84);
        check("mis_instret", instret, 32'd1);
        check("mis_reads", n_reads - rbase, 2);
        check("mis_req", 32'(mem_req), 32'd0);

        // RV32E core traps on x17
        check("rv32e_trap", 32'(trap2), 32'd1);
        check("rv32e_halted", 32'(halted2), 32'd1);
        check("rv32e_pc", pc2, 32'h80);
        check("rv32e_instret", instret2, 32'd0);

        // Reset while a store is stalled
        clear_mem();
        load(32'h80, enc_s(32'h40, 0, 0));
        hold_writes = 1'b1;
        do_reset();
        wbase = n_writes;
        cyc = 0;
        while (!(mem_req && mem_we) && (cyc < 20)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("store_pending", 32'(mem_req && mem_we), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_we", 32'(mem_we), 32'd0);
        check("post_rst_addr", mem_addr, 32'h80);
        check("post_rst_instret", instret, 32'd0);
        check("abandoned_writes", n_writes - wbase, 0);
        hold_writes = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
